glb_crd_rd_port: RTL

- Global-buffer-side responder for the coordinate fetch interface that the KNN engine initiates.
- Accepts coordinate read addresses via valid/ready, issues reads to the external coordinate SRAM bank (fixed 1-cycle read latency), and buffers returned words in a credit-protected output FIFO.
- Returns words to the requester via valid/ready, in order, with no loss under backpressure.
- Also arbitrates the loader's write port onto the same single-port SRAM; writes have priority.

---
 rtl/glb_crd_rd_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/glb_crd_rd_port.sv
// Global-buffer responder for KNN coordinate fetches: shares one SRAM port with the
// loader (writes win), tracks one in-flight read and returns words through a credit-guarded FIFO.
module glb_crd_rd_port #(
    parameter int unsigned SRAM_WIDTH = 256,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUGLB_Rst,
    input  logic [IDX_WIDTH-1:0]  KNNGLB_CrdAddr,
    input  logic                  KNNGLB_CrdAddrVld,
    output logic                  GLBKNN_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] GLBKNN_Crd,
    output logic                  GLBKNN_CrdVld,
    input  logic                  KNNGLB_CrdRdy,
    input  logic                  LDRGLB_WrEn,
    input  logic [IDX_WIDTH-1:0]  LDRGLB_WrAddr,
    input  logic [SRAM_WIDTH-1:0] LDRGLB_WrData,
    output logic                  GLBSRAM_En,
    output logic                  GLBSRAM_We,
    output logic [IDX_WIDTH-1:0]  GLBSRAM_Addr,
    output logic [SRAM_WIDTH-1:0] GLBSRAM_WrData,
    input  logic [SRAM_WIDTH-1:0] SRAMGLB_RdData,
    output logic [IDX_WIDTH:0]    GLBCCU_RdCnt
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RDCNT_W = IDX_WIDTH + 1;
    localparam logic [RDCNT_W-1:0] RDCNT_MAX = RDCNT_W'(1) << IDX_WIDTH;

    logic [SRAM_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtr;
    logic [CNT_W-1:0]      fifoCnt;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W-1:0]      occAfterPop;
    logic                  inFlight;
    logic                  wrEn;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Credit: a read may issue only if its word is guaranteed a FIFO slot on return.
    assign wrEn              = rst_n & LDRGLB_WrEn;
    assign GLBKNN_CrdVld     = (fifoCnt != '0);
    assign GLBKNN_Crd        = fifoMem[rdPtr];
    assign pop               = GLBKNN_CrdVld & KNNGLB_CrdRdy;
    assign occ               = fifoCnt + CNT_W'(inFlight);
    assign occAfterPop       = occ - CNT_W'(pop);
    assign GLBKNN_CrdAddrRdy = rst_n & ~LDRGLB_WrEn & ~CCUGLB_Rst
                               & (occAfterPop < CNT_W'(FIFO_DEPTH));
    assign accept            = KNNGLB_CrdAddrVld & GLBKNN_CrdAddrRdy;
    assign push              = inFlight & ~CCUGLB_Rst;

    // Single SRAM port: loader write first, then an accepted read.
    always_comb begin
        GLBSRAM_En     = 1'b0;
        GLBSRAM_We     = 1'b0;
        GLBSRAM_Addr   = '0;
        GLBSRAM_WrData = '0;
        if (wrEn) begin
            GLBSRAM_En     = 1'b1;
            GLBSRAM_We     = 1'b1;
            GLBSRAM_Addr   = LDRGLB_WrAddr;
            GLBSRAM_WrData = LDRGLB_WrData;
        end else if (accept) begin
            GLBSRAM_En   = 1'b1;
            GLBSRAM_Addr = KNNGLB_CrdAddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem[i] <= '0;
            end
        end else if (push) begin
            fifoMem[wrPtr] <= SRAMGLB_RdData;
        end
    end

    // Pointer, occupancy and in-flight tracking; the CCU flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            fifoCnt  <= '0;
            inFlight <= 1'b0;
        end else if (CCUGLB_Rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            fifoCnt  <= '0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= accept;
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            fifoCnt <= fifoCnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            GLBCCU_RdCnt <= '0;
        end else if (CCUGLB_Rst) begin
            GLBCCU_RdCnt <= '0;
        end else if (pop && (GLBCCU_RdCnt != RDCNT_MAX)) begin
            GLBCCU_RdCnt <= GLBCCU_RdCnt + RDCNT_W'(1);
        end
    end

    fifoNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifoCnt == CNT_W'(FIFO_DEPTH))));

endmodule
